mem_responder: RTL and testbench
================================

# mem_responder

Handshake memory responder that serves the CPU's fetch, load and store requests. The CPU side drives a request with address, write enable and write data, then waits for a one-cycle acknowledge. The block holds a DEPTH×DATA_W word array, inserts a programmable number of wait states, and protects an upper read-only region. It sits between the CPU fetch/execute sequencer and storage, replacing direct array access with a latency-tolerant interface.

## Interface
- DATA_W, 8, word width
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- WAIT_CYCLES, 1, wait states inserted per access, legal range 0..15
- RO_START, 12, first read-only address; RO_START = DEPTH disables protection

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- req  in  1  request valid; sampled only in IDLE
- we  in  1  1 = write, 0 = read; captured with req
- addr  in  ADDR_W  word address; captured with req
- wdata  in  DATA_W  write data; captured with req
- ack  out  1  one-cycle completion pulse, registered
- err  out  1  valid only with ack; 1 = write to read-only region refused
- rdata  out  DATA_W  read data; valid with ack, held until next ack or reset
- busy  out  1  high whenever state ≠ IDLE, decoded from the state register

## Operation
- Reset (RST=1 at an edge): state←IDLE, ack←0, err←0, rdata←0, wait counter←0, all DEPTH words←0. Reset overrides every other action, including a write due that same edge.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE: if req=1, capture we/addr/wdata into internal registers. Go to WAIT with counter←WAIT_CYCLES−1, or to ACCESS if WAIT_CYCLES=0. If req=0, stay in IDLE.
- WAIT: each edge, decrement the counter. At the edge where the counter is 0, go to ACCESS. Inputs are ignored.
- ACCESS: one cycle long. At its closing edge:
  - Read: rdata←mem[addr_q], err←0.
  - Write with addr_q < RO_START: mem[addr_q]←wdata_q, rdata←wdata_q, err←0.
  - Write with addr_q ≥ RO_START: memory is unchanged, rdata←mem[addr_q], err←1.
  - In all cases ack←1 and state←IDLE.
- ack and err are forced to 0 at every edge that does not close ACCESS, so each is a single-cycle pulse.
- req held high while busy has no effect. Inputs that change after capture do not affect the transaction in flight.
- req asserted in the ack cycle (state is IDLE) is accepted, which gives back-to-back transactions.
- Address arithmetic: addr is exactly ADDR_W bits with no wrap logic. The top address, DEPTH−1, is valid.

## Timing
- Request visible in cycle c0, accepted at the end of c0. With W = WAIT_CYCLES: c1..cW are WAIT cycles, cW+1 is ACCESS, and ack is high in cycle c0+W+2.
- Latency: W+2 cycles from the request cycle to the ack cycle. Maximum throughput is one transaction per W+2 cycles.
- busy is high from c1 through cW+1 and low in the ack cycle.
- Read-after-write to the same address, issued in the write's ack cycle, returns the new data.
- RST asserted during WAIT or ACCESS aborts the transaction. No ack is produced, memory is cleared, and busy is low in the next cycle.

## Test plan
- Reset then idle: hold RST 2 cycles, then req=0 for 10 cycles -> ack=0, err=0, busy=0, rdata=0 throughout.
- Write/read, WAIT_CYCLES=1: write addr=3, wdata=0xA5 in c0 -> ack in c3 with rdata=0xA5, err=0. Read addr=3 issued in c3 -> ack in c6 with rdata=0xA5.
- Read-only protection, RO_START=12: write addr=12, 0x5A -> ack with err=1 and rdata=0x00. A following read of addr=12 returns 0x00. A write to addr=11 succeeds with err=0.
- Zero-wait back-to-back, WAIT_CYCLES=0: req held high, writing addr 0..15 with data=addr -> ack every 2nd cycle. Reading back 15 (top address) returns 0x0F and 0 returns 0x00.
- Reset mid-access, WAIT_CYCLES=3: write addr=5, 0xFF, then assert RST during WAIT -> no ack. busy drops the cycle after RST. A subsequent read of addr=5 returns 0x00.
- Input stability: change addr/wdata/we during WAIT of a read of addr=2 (holding 0x22) -> ack returns 0x22, and memory at the new addr is unchanged.

Source files
------------

// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
//
// Request/acknowledge bus between the CPU fetch/execute sequencer and the
// memory responder. The CPU (master) raises req together with we/addr/wdata.
// The responder (slave) returns a one-cycle ack with err/rdata and exposes
// busy while a transaction is in flight.
//
// Signals:
//   req    master->slave  request valid (sampled by the slave only when idle)
//   we     master->slave  1 = write, 0 = read
//   addr   master->slave  word address, ADDR_W bits
//   wdata  master->slave  write data, DATA_W bits
//   ack    slave->master  one-cycle completion pulse
//   err    slave->master  valid with ack; 1 = write to read-only region refused
//   rdata  slave->master  read data, valid with ack, held until the next ack
//   busy   slave->master  high while a transaction is in progress
// ----------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ack,
        input  err,
        input  rdata,
        input  busy
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ack,
        output err,
        output rdata,
        output busy
    );

endinterface

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//
// Latency-tolerant memory responder for CPU fetch, load and store requests.
// Holds a DEPTH x DATA_W word array, inserts WAIT_CYCLES wait states before
// each access and refuses writes at or above RO_START.
//
// Parameters:
//   DATA_W      word width
//   ADDR_W      address width, DEPTH = 2**ADDR_W
//   WAIT_CYCLES wait states per access, 0..15
//   RO_START    first read-only address; RO_START = DEPTH disables protection
//
// Ports:
//   CLK  in   clock, all state changes on the rising edge
//   RST  in   synchronous active-high reset; clears state, outputs and memory
//   bus  slave modport of mem_responder_if
//          req/we/addr/wdata  request, captured only while idle
//          ack/err/rdata      registered response, ack/err are 1-cycle pulses
//          busy               decoded from the state register
//
// Transaction timing with W = WAIT_CYCLES: request in c0, WAIT in c1..cW,
// ACCESS in cW+1, ack in cW+2.
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned RO_START    = 12
) (
    input  logic          CLK,
    input  logic          RST,
    mem_responder_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Counter load value on acceptance; unused when WAIT_CYCLES is zero.
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0
                                                          : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;

    // Captured address falls inside the protected upper region.
    logic              addr_ro;
    assign addr_ro = (32'(addr_q) >= RO_START);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        mem_we  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_INIT;
                    end
                end
            end

            ST_WAIT: begin
                // Counter holds at zero on the exit edge; its value is
                // reloaded on the next acceptance anyway.
                if (wcnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end

            ST_ACCESS: begin
                ack_d   = 1'b1;
                state_d = ST_IDLE;
                if (!we_q) begin
                    rdata_d = mem_q[addr_q];
                end else if (!addr_ro) begin
                    mem_we  = 1'b1;
                    rdata_d = wdata_q;
                end else begin
                    // Refused write reports the unchanged stored word.
                    rdata_d = mem_q[addr_q];
                    err_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage array; reset clears every word and wins over a pending write.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
//
// Three responder instances share clock and reset:
//   d=0 : WAIT_CYCLES=1, RO_START=12
//   d=1 : WAIT_CYCLES=0, RO_START=16 (protection disabled)
//   d=2 : WAIT_CYCLES=3, RO_START=12
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       req_v   [3];
    logic       we_v    [3];
    logic [3:0] addr_v  [3];
    logic [7:0] wdata_v [3];
    logic       ack_v   [3];
    logic       err_v   [3];
    logic       busy_v  [3];
    logic [7:0] rdata_v [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W  = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        localparam int unsigned RO = (g == 1) ? 16 : 12;

        mem_responder_if #(.DATA_W(8), .ADDR_W(4)) bus ();

        assign bus.req     = req_v[g];
        assign bus.we      = we_v[g];
        assign bus.addr    = addr_v[g];
        assign bus.wdata   = wdata_v[g];
        assign ack_v[g]    = bus.ack;
        assign err_v[g]    = bus.err;
        assign busy_v[g]   = bus.busy;
        assign rdata_v[g]  = bus.rdata;

        mem_responder #(
            .DATA_W      (8),
            .ADDR_W      (4),
            .WAIT_CYCLES (W),
            .RO_START    (RO)
        ) u_dut (
            .CLK (clk),
            .RST (rst),
            .bus (bus)
        );
    end

    int nvec = 0;
    int nerr = 0;

    // Reference model: word contents and last acknowledged read data.
    logic [7:0] mdl     [3][16];
    logic [7:0] last_rd [3];

    function automatic int wc_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    function automatic int ro_of(input int d);
        return (d == 1) ? 16 : 12;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            for (int a = 0; a < 16; a++) mdl[d][a] = 8'h00;
            last_rd[d] = 8'h00;
        end
    endtask

    task automatic model_apply(input int d, input logic w, input logic [3:0] a,
                               input logic [7:0] wd,
                               output logic [7:0] erd, output logic eer);
        if (!w) begin
            erd = mdl[d][a];
            eer = 1'b0;
        end else if (int'(a) < ro_of(d)) begin
            mdl[d][a] = wd;
            erd = wd;
            eer = 1'b0;
        end else begin
            erd = mdl[d][a];
            eer = 1'b1;
        end
        last_rd[d] = erd;
    endtask

    // Expected busy pattern: high for cycles 1..W+1, low in the ack cycle.
    function automatic logic [31:0] busy_exp(input int d);
        return ((32'd1 << (wc_of(d) + 2)) - 32'd1) & ~32'd1;
    endfunction

    // Issue one request at the current falling edge and observe it until ack.
    // hold keeps req high afterwards; scramble disturbs the inputs mid-flight.
    // Returns at the falling edge of the ack cycle (lat = -1 on timeout).
    task automatic run_txn(input int d, input logic w, input logic [3:0] a,
                           input logic [7:0] wd, input bit hold, input bit scramble,
                           output int lat, output logic [7:0] rd,
                           output logic er, output logic [31:0] bm);
        req_v[d]   = 1'b1;
        we_v[d]    = w;
        addr_v[d]  = a;
        wdata_v[d] = wd;
        lat = -1;
        rd  = 8'h00;
        er  = 1'b0;
        bm  = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            bm[k] = busy_v[d];
            if (ack_v[d]) begin
                lat = k;
                rd  = rdata_v[d];
                er  = err_v[d];
                break;
            end
            if (k == 1) begin
                if (!hold) req_v[d] = 1'b0;
                if (scramble) begin
                    we_v[d]    = 1'b1;
                    addr_v[d]  = a ^ 4'h4;
                    wdata_v[d] = 8'hEE;
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = 4'h0; wdata_v[d] = 8'h00;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                nvec++;
                if (ack_v[d] !== 1'b0 || err_v[d] !== 1'b0 || busy_v[d] !== 1'b0 ||
                    rdata_v[d] !== 8'h00) begin
                    nerr++;
                    $display("FAIL reset_idle d=%0d c=%0d got ack=%b err=%b busy=%b rdata=%h exp 0 0 0 00",
                             d, c, ack_v[d], err_v[d], busy_v[d], rdata_v[d]);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_write_read();
        int lat; logic [7:0] rd; logic er; logic [31:0] bm;
        logic [7:0] erd; logic eer;
        // Write then read issued in the write's ack cycle.
        run_txn(0, 1'b1, 4'd3, 8'hA5, 1'b1, 1'b0, lat, rd, er, bm);
        model_apply(0, 1'b1, 4'd3, 8'hA5, erd, eer);
        nvec++;
        if (lat !== 3 || rd !== erd || er !== eer || bm !== busy_exp(0)) begin
            nerr++;
            $display("FAIL wr3 got lat=%0d rd=%h err=%b busy=%h exp lat=3 rd=%h err=%b busy=%h",
                     lat, rd, er, bm, erd, eer, busy_exp(0));
        end
        run_txn(0, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, lat, rd, er, bm);
        model_apply(0, 1'b0, 4'd3, 8'h00, erd, eer);
        nvec++;
        if (lat !== 3 || rd !== 8'hA5 || rd !== erd || er !== 1'b0) begin
            nerr++;
            $display("FAIL raw3 got lat=%0d rd=%h err=%b exp lat=3 rd=a5 err=0", lat, rd, er);
        end
        req_v[0] = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_readonly();
        int lat; logic [7:0] rd; logic er; logic [31:0] bm;
        logic [7:0] erd; logic eer;
        run_txn(0, 1'b1, 4'd12, 8'h5A, 1'b0, 1'b0, lat, rd, er, bm);
        model_apply(0, 1'b1, 4'd12, 8'h5A, erd, eer);
        nvec++;
        if (lat !== 3 || rd !== 8'h00 || er !== 1'b1 || rd !== erd || er !== eer) begin
            nerr++;
            $display("FAIL ro_wr12 got lat=%0d rd=%h err=%b exp lat=3 rd=00 err=1", lat, rd, er);
        end
        run_txn(0, 1'b0, 4'd12, 8'h00, 1'b0, 1'b0, lat, rd, er, bm);
        model_apply(0, 1'b0, 4'd12, 8'h00, erd, eer);
        nvec++;
        if (lat !== 3 || rd !== 8'h00 || er !== 1'b0) begin
            nerr++;
            $display("FAIL ro_rd12 got lat=%0d rd=%h err=%b exp lat=3 rd=00 err=0", lat, rd, er);
        end
        run_txn(0, 1'b1, 4'd11, 8'h3C, 1'b0, 1'b0, lat, rd, er, bm);
        model_apply(0, 1'b1, 4'd11, 8'h3C, erd, eer);
        nvec++;
        if (lat !== 3 || rd !== 8'h3C || er !== 1'b0) begin
            nerr++;
            $display("FAIL ro_wr11 got lat=%0d rd=%h err=%b exp lat=3 rd=3c err=0", lat, rd, er);
        end
        run_txn(0, 1'b0, 4'd11, 8'h00, 1'b0, 1'b0, lat, rd, er, bm);
        model_apply(0, 1'b0, 4'd11, 8'h00, erd, eer);
        nvec++;
        if (rd !== 8'h3C || er !== 1'b0) begin
            nerr++;
            $display("FAIL ro_rd11 got rd=%h err=%b exp rd=3c err=0", rd, er);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int lat; logic [7:0] rd; logic er; logic [31:0] bm;
        logic [7:0] erd; logic eer;
        // req stays high throughout: one ack every second cycle.
        for (int a = 0; a < 16; a++) begin
            run_txn(1, 1'b1, 4'(a), 8'(a), 1'b1, 1'b0, lat, rd, er, bm);
            model_apply(1, 1'b1, 4'(a), 8'(a), erd, eer);
            nvec++;
            if (lat !== 2 || rd !== erd || er !== eer || bm !== busy_exp(1)) begin
                nerr++;
                $display("FAIL b2b_wr a=%0d got lat=%0d rd=%h err=%b busy=%h exp lat=2 rd=%h err=%b busy=%h",
                         a, lat, rd, er, bm, erd, eer, busy_exp(1));
            end
        end
        run_txn(1, 1'b0, 4'd15, 8'h00, 1'b1, 1'b0, lat, rd, er, bm);
        model_apply(1, 1'b0, 4'd15, 8'h00, erd, eer);
        nvec++;
        if (lat !== 2 || rd !== 8'h0F || er !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_rd15 got lat=%0d rd=%h err=%b exp lat=2 rd=0f err=0", lat, rd, er);
        end
        run_txn(1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, lat, rd, er, bm);
        model_apply(1, 1'b0, 4'd0, 8'h00, erd, eer);
        nvec++;
        if (lat !== 2 || rd !== 8'h00 || er !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_rd0 got lat=%0d rd=%h err=%b exp lat=2 rd=00 err=0", lat, rd, er);
        end
        req_v[1] = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        int lat; logic [7:0] rd; logic er; logic [31:0] bm;
        logic [7:0] erd; logic eer;
        req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 4'd5; wdata_v[2] = 8'hFF;
        @(negedge clk);                 // c1: WAIT
        req_v[2] = 1'b0;
        @(negedge clk);                 // c2: WAIT, reset applied at its end
        rst = 1'b1;
        @(negedge clk);                 // c3
        rst = 1'b0;
        model_clear();
        nvec++;
        if (busy_v[2] !== 1'b0 || ack_v[2] !== 1'b0) begin
            nerr++;
            $display("FAIL rstmid_busy got busy=%b ack=%b exp busy=0 ack=0", busy_v[2], ack_v[2]);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            nvec++;
            if (ack_v[2] !== 1'b0 || busy_v[2] !== 1'b0) begin
                nerr++;
                $display("FAIL rstmid_noack c=%0d got ack=%b busy=%b exp 0 0", c, ack_v[2], busy_v[2]);
            end
        end
        run_txn(2, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, lat, rd, er, bm);
        model_apply(2, 1'b0, 4'd5, 8'h00, erd, eer);
        nvec++;
        if (lat !== 5 || rd !== 8'h00 || er !== 1'b0 || bm !== busy_exp(2)) begin
            nerr++;
            $display("FAIL rstmid_rd5 got lat=%0d rd=%h err=%b busy=%h exp lat=5 rd=00 err=0 busy=%h",
                     lat, rd, er, bm, busy_exp(2));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_input_stability();
        int lat; logic [7:0] rd; logic er; logic [31:0] bm;
        logic [7:0] erd; logic eer;
        run_txn(2, 1'b1, 4'd2, 8'h22, 1'b0, 1'b0, lat, rd, er, bm);
        model_apply(2, 1'b1, 4'd2, 8'h22, erd, eer);
        nvec++;
        if (lat !== 5 || rd !== 8'h22 || er !== 1'b0) begin
            nerr++;
            $display("FAIL stab_wr2 got lat=%0d rd=%h err=%b exp lat=5 rd=22 err=0", lat, rd, er);
        end
        // Read of 2 while inputs are switched to a write of 0xEE to addr 6.
        run_txn(2, 1'b0, 4'd2, 8'h00, 1'b0, 1'b1, lat, rd, er, bm);
        model_apply(2, 1'b0, 4'd2, 8'h00, erd, eer);
        nvec++;
        if (lat !== 5 || rd !== 8'h22 || er !== 1'b0) begin
            nerr++;
            $display("FAIL stab_rd2 got lat=%0d rd=%h err=%b exp lat=5 rd=22 err=0", lat, rd, er);
        end
        run_txn(2, 1'b0, 4'd6, 8'h00, 1'b0, 1'b0, lat, rd, er, bm);
        model_apply(2, 1'b0, 4'd6, 8'h00, erd, eer);
        nvec++;
        if (rd !== erd || er !== 1'b0) begin
            nerr++;
            $display("FAIL stab_rd6 got rd=%h err=%b exp rd=%h err=0", rd, er, erd);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        int lat; logic [7:0] rd; logic er; logic [31:0] bm;
        logic [7:0] erd; logic eer;
        logic w; logic [3:0] a; logic [7:0] wd; bit hold; int gap;
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                w    = 1'($urandom);
                a    = 4'($urandom);
                wd   = 8'($urandom);
                hold = 1'($urandom);
                run_txn(d, w, a, wd, hold, 1'b0, lat, rd, er, bm);
                model_apply(d, w, a, wd, erd, eer);
                nvec++;
                if (lat !== wc_of(d) + 2 || rd !== erd || er !== eer || bm !== busy_exp(d)) begin
                    nerr++;
                    $display("FAIL rnd d=%0d n=%0d we=%b a=%0d got lat=%0d rd=%h err=%b busy=%h exp lat=%0d rd=%h err=%b busy=%h",
                             d, n, w, a, lat, rd, er, bm, wc_of(d) + 2, erd, eer, busy_exp(d));
                end
                gap = hold ? 0 : int'($urandom_range(1, 3));
                if (gap > 0) req_v[d] = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    nvec++;
                    if (ack_v[d] !== 1'b0 || err_v[d] !== 1'b0 || busy_v[d] !== 1'b0 ||
                        rdata_v[d] !== last_rd[d]) begin
                        nerr++;
                        $display("FAIL rnd_idle d=%0d n=%0d got ack=%b err=%b busy=%b rdata=%h exp 0 0 0 %h",
                                 d, n, ack_v[d], err_v[d], busy_v[d], rdata_v[d], last_rd[d]);
                    end
                end
            end
            req_v[d] = 1'b0;
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_v[d] = 1'b0; we_v[d] = 1'b0; addr_v[d] = 4'h0; wdata_v[d] = 8'h00;
        end
        test_reset();
        test_write_read();
        test_readonly();
        test_back_to_back();
        test_reset_mid();
        test_input_stability();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
